// File: rtl/cr_prefix_fe_blk_ctlr_if.sv
// Input beat stream into the prefix feature-extraction controller.
//   in_valid  : beat valid (source -> controller)
//   in_ready  : beat accepted when in_valid && in_ready (controller -> source)
//   in_data   : 64-bit data, byte lane i = bits [8i+7:8i]
//   in_vbytes : thermometer lane valids starting at bit 0
//   in_eob    : last beat of the buffer
interface cr_prefix_fe_blk_ctlr_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_vbytes;
    logic        in_eob;

    modport master (output in_valid, in_data, in_vbytes, in_eob, input in_ready);
    modport slave  (input in_valid, in_data, in_vbytes, in_eob, output in_ready);
endinterface

// File: rtl/cr_prefix_fe_blk_ctlr.sv
// Prefix feature-extraction block controller.
// Slices a 64-bit byte-lane input stream into up to four CHUNK_BYTES chunks and
// sequences the feature counter: lane data/valids, chunk select, end-of-chunk
// strobe and prior-match feedback. Pulses fe_done when a buffer's counts are final.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_if           : input beat stream (slave side)
//   fe_prior_out    : per-lane match feedback from the counter
//   fe_char_in      : lane data to the counter (registered)
//   fe_char_vbytes  : lane valids to the counter (registered)
//   fe_prior_in     : prior match bits to the counter (registered)
//   fe_sel_1k       : current chunk index (registered)
//   fe_ctlr_eodb    : one-cycle end-of-chunk strobe (registered)
//   fe_done         : one-cycle pulse, buffer counts final
//   fe_num_chunks   : chunks flushed for the buffer, valid with fe_done
//   err_vbytes      : one-cycle pulse, accepted beat had non-thermometer vbytes
module cr_prefix_fe_blk_ctlr #(
    parameter int CHUNK_BYTES = 1024,
    parameter int FE_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cr_prefix_fe_blk_ctlr_if.slave in_if,
    input  logic [7:0]             fe_prior_out,
    output logic [63:0]            fe_char_in,
    output logic [7:0]             fe_char_vbytes,
    output logic [7:0]             fe_prior_in,
    output logic [1:0]             fe_sel_1k,
    output logic                   fe_ctlr_eodb,
    output logic                   fe_done,
    output logic [2:0]             fe_num_chunks,
    output logic                   err_vbytes
);
    localparam logic [10:0] CHUNK_L    = 11'(CHUNK_BYTES);
    localparam logic [1:0]  FLUSH_LAST = 2'(FE_LAT);

    typedef enum logic [2:0] {ST_RUN, ST_FLUSH, ST_SPLIT, ST_DISCARD, ST_DONE} state_e;

    // Number of contiguous ones starting at bit 0.
    function automatic logic [3:0] lead_ones(input logic [7:0] v);
        logic [3:0] n;
        logic       cont;
        n    = 4'd0;
        cont = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cont && v[i]) n = n + 4'd1;
            else              cont = 1'b0;
        end
        return n;
    endfunction

    // Thermometer mask with the low n bits set.
    function automatic logic [7:0] therm(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
        return m;
    endfunction

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  nchunk_q, nchunk_d;      // chunks flushed so far; low bits are the chunk index
    logic [1:0]  fcnt_q, fcnt_d;
    logic        eob_pend_q, eob_pend_d;
    logic        split_pend_q, split_pend_d;
    logic [63:0] sv_data_q, sv_data_d;
    logic [3:0]  sv_r_q, sv_r_d;          // lanes already presented from the saved beat
    logic [3:0]  sv_rem_q, sv_rem_d;      // lanes left over for the next chunk
    logic        sv_eob_q, sv_eob_d;
    logic        in_ready_q, in_ready_d;
    logic [63:0] char_q, char_d;
    logic [7:0]  vb_q, vb_d;
    logic [7:0]  prior_q, prior_d;
    logic [1:0]  sel_q, sel_d;
    logic        eodb_q, eodb_d;
    logic        done_q, done_d;
    logic [2:0]  num_q, num_d;
    logic        err_q, err_d;

    logic        beat_s;
    logic [3:0]  n_s;
    logic [10:0] n_ext_s;
    logic [10:0] r_s;
    logic        nonthermo_s;

    assign beat_s      = in_if.in_valid && in_ready_q;
    assign n_s         = lead_ones(in_if.in_vbytes);
    assign n_ext_s     = {7'd0, n_s};
    assign r_s         = CHUNK_L - cnt_q;
    assign nonthermo_s = (therm(n_s) != in_if.in_vbytes);

    assign in_if.in_ready = in_ready_q;
    assign fe_char_in     = char_q;
    assign fe_char_vbytes = vb_q;
    assign fe_prior_in    = prior_q;
    assign fe_sel_1k      = sel_q;
    assign fe_ctlr_eodb   = eodb_q;
    assign fe_done        = done_q;
    assign fe_num_chunks  = num_q;
    assign err_vbytes     = err_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= 11'd0;
            nchunk_q     <= 3'd0;
            fcnt_q       <= 2'd0;
            eob_pend_q   <= 1'b0;
            split_pend_q <= 1'b0;
            sv_data_q    <= 64'd0;
            sv_r_q       <= 4'd0;
            sv_rem_q     <= 4'd0;
            sv_eob_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            char_q       <= 64'd0;
            vb_q         <= 8'h00;
            prior_q      <= 8'h00;
            sel_q        <= 2'd0;
            eodb_q       <= 1'b0;
            done_q       <= 1'b0;
            num_q        <= 3'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nchunk_q     <= nchunk_d;
            fcnt_q       <= fcnt_d;
            eob_pend_q   <= eob_pend_d;
            split_pend_q <= split_pend_d;
            sv_data_q    <= sv_data_d;
            sv_r_q       <= sv_r_d;
            sv_rem_q     <= sv_rem_d;
            sv_eob_q     <= sv_eob_d;
            in_ready_q   <= in_ready_d;
            char_q       <= char_d;
            vb_q         <= vb_d;
            prior_q      <= prior_d;
            sel_q        <= sel_d;
            eodb_q       <= eodb_d;
            done_q       <= done_d;
            num_q        <= num_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output logic. Outputs lag the state by one cycle, so
    // FLUSH state cycles are seen on the outputs as FE_LAT+1 idle cycles ending
    // with the strobe, always after the last beat of the chunk was presented.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nchunk_d     = nchunk_q;
        fcnt_d       = 2'd0;
        eob_pend_d   = eob_pend_q;
        split_pend_d = split_pend_q;
        sv_data_d    = sv_data_q;
        sv_r_d       = sv_r_q;
        sv_rem_d     = sv_rem_q;
        sv_eob_d     = sv_eob_q;
        char_d       = char_q;
        vb_d         = 8'h00;
        sel_d        = nchunk_q[1:0];
        eodb_d       = 1'b0;
        done_d       = 1'b0;
        num_d        = 3'd0;
        err_d        = 1'b0;

        // Prior match bits follow the counter while data flows; a new chunk starts clean.
        if (eodb_q)              prior_d = 8'h00;
        else if (vb_q != 8'h00)  prior_d = fe_prior_out;
        else                     prior_d = prior_q;

        case (state_q)
            ST_RUN: begin
                if (beat_s) begin
                    err_d = nonthermo_s;
                    if (in_if.in_eob && (n_s == 4'd0) && (cnt_q == 11'd0)) begin
                        // Empty tail beat: chunk 0 still needs a strobe, later chunks are already flushed.
                        if (nchunk_q == 3'd0) begin
                            state_d    = ST_FLUSH;
                            eob_pend_d = 1'b1;
                        end else begin
                            state_d    = ST_DONE;
                        end
                    end else if (n_ext_s > r_s) begin
                        // Beat straddles the chunk boundary: show the low lanes now, keep the rest.
                        char_d       = in_if.in_data;
                        vb_d         = therm(r_s[3:0]);
                        sv_data_d    = in_if.in_data;
                        sv_r_d       = r_s[3:0];
                        sv_rem_d     = n_s - r_s[3:0];
                        sv_eob_d     = in_if.in_eob;
                        split_pend_d = 1'b1;
                        state_d      = ST_FLUSH;
                    end else begin
                        char_d = in_if.in_data;
                        vb_d   = therm(n_s);
                        cnt_d  = cnt_q + n_ext_s;
                        if ((n_ext_s == r_s) || in_if.in_eob) begin
                            state_d    = ST_FLUSH;
                            eob_pend_d = in_if.in_eob;
                        end else begin
                            state_d    = ST_RUN;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q + 2'd1;
                if (fcnt_q == FLUSH_LAST) begin
                    eodb_d       = 1'b1;
                    fcnt_d       = 2'd0;
                    cnt_d        = 11'd0;
                    nchunk_d     = nchunk_q + 3'd1;
                    eob_pend_d   = 1'b0;
                    split_pend_d = 1'b0;
                    if (eob_pend_q || ((nchunk_q == 3'd3) && split_pend_q && sv_eob_q)) begin
                        state_d = ST_DONE;
                    end else if (nchunk_q == 3'd3) begin
                        state_d = ST_DISCARD;
                    end else if (split_pend_q) begin
                        state_d = ST_SPLIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_SPLIT: begin
                char_d = sv_data_q >> {sv_r_q, 3'b000};
                vb_d   = therm(sv_rem_q);
                cnt_d  = {7'd0, sv_rem_q};
                if (sv_eob_q) begin
                    state_d    = ST_FLUSH;
                    eob_pend_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DISCARD: begin
                if (beat_s) begin
                    err_d = nonthermo_s;
                    if (in_if.in_eob) state_d = ST_DONE;
                    else              state_d = ST_DISCARD;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                num_d    = nchunk_q;
                nchunk_d = 3'd0;
                cnt_d    = 11'd0;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        in_ready_d = (state_d == ST_RUN) || (state_d == ST_DISCARD);
    end
endmodule

// File: tb/tb_cr_prefix_fe_blk_ctlr.sv
module tb_cr_prefix_fe_blk_ctlr;
    logic        clk;
    logic        rst_n;
    logic [7:0]  fe_prior_out;
    logic [63:0] fe_char_in;
    logic [7:0]  fe_char_vbytes;
    logic [7:0]  fe_prior_in;
    logic [1:0]  fe_sel_1k;
    logic        fe_ctlr_eodb;
    logic        fe_done;
    logic [2:0]  fe_num_chunks;
    logic        err_vbytes;

    cr_prefix_fe_blk_ctlr_if bus ();

    cr_prefix_fe_blk_ctlr #(.CHUNK_BYTES(1024), .FE_LAT(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (bus),
        .fe_prior_out   (fe_prior_out),
        .fe_char_in     (fe_char_in),
        .fe_char_vbytes (fe_char_vbytes),
        .fe_prior_in    (fe_prior_in),
        .fe_sel_1k      (fe_sel_1k),
        .fe_ctlr_eodb   (fe_ctlr_eodb),
        .fe_done        (fe_done),
        .fe_num_chunks  (fe_num_chunks),
        .err_vbytes     (err_vbytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Event monitor, sampled on the falling edge.
    int         cyc        = 0;
    int         eodb_n     = 0;
    int         done_n     = 0;
    int         err_n      = 0;
    int         pres_bytes = 0;
    int         last_pres  = 0;
    int         last_gap   = 0;
    int         viol_n     = 0;
    logic [2:0] last_num   = 3'd0;
    logic [7:0] sel_hist   = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fe_ctlr_eodb) begin
            eodb_n   <= eodb_n + 1;
            sel_hist <= {sel_hist[5:0], fe_sel_1k};
            last_gap <= cyc - last_pres;
            if (cyc - last_pres < 2) viol_n <= viol_n + 1;
        end
        if (fe_char_vbytes != 8'h00) begin
            last_pres  <= cyc;
            pres_bytes <= pres_bytes + $countones(fe_char_vbytes);
        end
        if (fe_done) begin
            done_n   <= done_n + 1;
            last_num <= fe_num_chunks;
        end
        if (err_vbytes) err_n <= err_n + 1;
    end

    int e0, d0, b0, r0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic snap();
        e0 = eodb_n;
        d0 = done_n;
        b0 = pres_bytes;
        r0 = err_n;
    endtask

    // Offer one beat and return in the cycle after it was accepted.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] vb, input logic eob);
        int guard;
        guard         = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_vbytes = vb;
        bus.in_eob    = eob;
        while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 128'd0, 128'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_eob   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        fe_prior_out  = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'd0;
        bus.in_vbytes = 8'h00;
        bus.in_eob    = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              {fe_char_in, fe_char_vbytes, fe_prior_in, fe_sel_1k, fe_ctlr_eodb,
               fe_done, fe_num_chunks, err_vbytes, bus.in_ready}, 128'd1);
        rst_n = 1'b1;
        step();

        // 1: exactly one chunk of full beats, then an empty eob beat.
        fe_prior_out = 8'h5a;
        snap();
        for (int i = 0; i < 128; i++) send_beat({32'h1234_5678, 32'(i)}, 8'hff, 1'b0);
        check("t1_last_vb", fe_char_vbytes, 8'hff);
        check("t1_last_data", fe_char_in, 64'h1234_5678_0000_007f);
        check("t1_prior_loaded", fe_prior_in, 8'h5a);
        check("t1_ready_low", bus.in_ready, 1'b0);
        send_beat(64'd0, 8'h00, 1'b1);
        idle(4);
        check("t1_eodb_count", eodb_n - e0, 1);
        check("t1_eodb_sel", sel_hist[1:0], 2'd0);
        check("t1_eodb_gap", last_gap, 2);
        check("t1_done_count", done_n - d0, 1);
        check("t1_num_chunks", last_num, 3'd1);
        check("t1_bytes", pres_bytes - b0, 1024);
        check("t1_prior_cleared", fe_prior_in, 8'h00);

        // 2: 4-byte beat at cnt = 1022 splits across chunks 0 and 1.
        snap();
        for (int i = 0; i < 127; i++) send_beat(64'hffff_ffff_ffff_ffff, 8'hff, 1'b0);
        send_beat(64'h0000_0000_0000_0000, 8'h3f, 1'b0);
        send_beat(64'h8877_6655_4433_2211, 8'h0f, 1'b0);
        check("t2_head_vb", fe_char_vbytes, 8'h03);
        check("t2_head_sel", fe_sel_1k, 2'd0);
        check("t2_head_data", fe_char_in, 64'h8877_6655_4433_2211);
        check("t2_ready_c1", bus.in_ready, 1'b0);
        step();
        check("t2_flush_vb", {fe_char_vbytes, fe_ctlr_eodb, bus.in_ready}, {8'h00, 1'b0, 1'b0});
        step();
        check("t2_strobe", {fe_ctlr_eodb, fe_sel_1k, bus.in_ready}, {1'b1, 2'd0, 1'b0});
        step();
        check("t2_tail_vb", fe_char_vbytes, 8'h03);
        check("t2_tail_sel", fe_sel_1k, 2'd1);
        check("t2_tail_data", fe_char_in, 64'h0000_8877_6655_4433);
        check("t2_tail_eodb", fe_ctlr_eodb, 1'b0);
        send_beat(64'd0, 8'h00, 1'b1);
        idle(6);
        check("t2_eodb_seq", {eodb_n - e0, sel_hist[3:0]}, {32'd2, 4'b0001});
        check("t2_num_chunks", {done_n - d0, last_num}, {32'd1, 3'd2});
        check("t2_bytes", pres_bytes - b0, 1026);

        // 3: 4800 bytes; four chunks flushed, the tail discarded.
        snap();
        for (int i = 0; i < 600; i++) send_beat({32'hbeef_0000, 32'(i)}, 8'hff, (i == 599));
        idle(6);
        check("t3_eodb_count", eodb_n - e0, 4);
        check("t3_eodb_sels", sel_hist, 8'h1b);
        check("t3_done", {done_n - d0, last_num}, {32'd1, 3'd4});
        check("t3_bytes", pres_bytes - b0, 4096);

        // 4: single short beat with eob.
        snap();
        send_beat(64'h0000_0000_00cc_bbaa, 8'h07, 1'b1);
        check("t4_vb", {fe_char_vbytes, fe_sel_1k}, {8'h07, 2'd0});
        idle(6);
        check("t4_eodb", {eodb_n - e0, sel_hist[1:0]}, {32'd1, 2'd0});
        check("t4_done", {done_n - d0, last_num}, {32'd1, 3'd1});

        // 5: exactly one chunk, then a separate empty eob beat.
        snap();
        send_beat(64'h1111_1111_1111_1111, 8'hff, 1'b0);
        check("t5_first_sel", {fe_char_vbytes, fe_sel_1k}, {8'hff, 2'd0});
        for (int i = 1; i < 128; i++) send_beat(64'h2222_2222_2222_2222, 8'hff, 1'b0);
        send_beat(64'd0, 8'h00, 1'b1);
        idle(6);
        check("t5_eodb_count", eodb_n - e0, 1);
        check("t5_done", {done_n - d0, last_num}, {32'd1, 3'd1});

        // 6: non-thermometer vbytes, then reset in the middle of a flush.
        snap();
        send_beat(64'h0000_0000_0033_0011, 8'h05, 1'b0);
        check("t6_err_pulse", {err_vbytes, fe_char_vbytes}, {1'b1, 8'h01});
        step();
        check("t6_err_clear", err_vbytes, 1'b0);
        for (int i = 0; i < 127; i++) send_beat(64'h3333_3333_3333_3333, 8'hff, 1'b0);
        send_beat(64'h4444_4444_4444_4444, 8'hff, 1'b0);
        check("t6_count_1_byte", fe_char_vbytes, 8'h7f);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              {fe_char_in, fe_char_vbytes, fe_prior_in, fe_sel_1k, fe_ctlr_eodb,
               fe_done, fe_num_chunks, err_vbytes, bus.in_ready}, 128'd1);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("t6_no_eodb", eodb_n - e0, 0);
        send_beat(64'h0000_0000_0000_0077, 8'h01, 1'b1);
        check("t6_restart", {fe_char_vbytes, fe_sel_1k, fe_char_in[7:0]}, {8'h01, 2'd0, 8'h77});
        idle(6);
        check("t6_done", {eodb_n - e0, done_n - d0, last_num}, {32'd1, 32'd1, 3'd1});
        check("t6_err_count", err_n - r0, 1);
        check("strobe_spacing", viol_n, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
